// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array output side.
package systolic_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } drain_state_t;

   // Wide enough to hold any intermediate requantized value before clamping.
   localparam int SAT_W = 128;

   function automatic int num_pe(input int n);
      return n * n;
   endfunction

   // Clamp a signed value to the range of a dw-bit signed integer.
   function automatic logic signed [SAT_W-1:0] sat_to_width(
      input logic signed [SAT_W-1:0] v,
      input int                      dw
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
      lo = ~hi;
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, then saturate.
module acc_requant
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 64,
   parameter int SHIFT_W    = 6
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic        [SHIFT_W-1:0]    shift,
   output logic        [DATA_WIDTH-1:0] data
);

   // One extra bit so adding the rounding constant cannot overflow.
   localparam int EW = ACC_WIDTH + 1;

   logic        [31:0]   s;
   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] half;
   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] v;

   always_comb begin
      s = (32'(shift) > 32'(ACC_WIDTH - 1)) ? 32'(ACC_WIDTH - 1) : 32'(shift);
      ext = EW'(acc);
      half = '0;
      if (s != 32'd0) half = $signed(EW'(1) << (s - 32'd1));
      sum = ext + half;
      v = sum >>> s;
      data = DATA_WIDTH'(sat_to_width(SAT_W'(v), DATA_WIDTH));
   end

endmodule

// File: rtl/acc_drain.sv
// Snapshots all PE accumulators on start and streams requantized results row-major.
module acc_drain
   import systolic_pkg::*;
#(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 64,
   parameter int SHIFT_W    = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [N*N*ACC_WIDTH-1:0]  acc_i,
   input  logic [SHIFT_W-1:0]        shift_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [DATA_WIDTH-1:0]     out_data_o,
   output logic [$clog2(N)-1:0]      out_row_o,
   output logic [$clog2(N)-1:0]      out_col_o,
   output logic                      out_last_o
);

   localparam int NUM_PE = num_pe(N);
   localparam int IDX_W  = $clog2(NUM_PE);
   localparam int RC_W   = $clog2(N);

   drain_state_t                 state;
   logic        [IDX_W-1:0]      idx;
   logic        [ACC_WIDTH-1:0]  snap [NUM_PE];
   logic        [SHIFT_W-1:0]    shift_q;
   logic                         done_q;
   logic                         is_last;
   logic signed [ACC_WIDTH-1:0]  sel_acc;

   assign is_last = (idx == IDX_W'(NUM_PE - 1));

   // Stream handshake: a beat transfers on any clock edge where out_valid_o and
   // out_ready_i are both high; once valid rises it stays high, with the beat
   // unchanged, until that transfer happens.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < NUM_PE; k++) snap[k] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  for (int k = 0; k < NUM_PE; k++)
                     snap[k] <= acc_i[k*ACC_WIDTH +: ACC_WIDTH];
                  shift_q <= shift_i;
                  idx     <= '0;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               if (out_ready_i) begin
                  if (is_last) begin
                     state  <= IDLE;
                     idx    <= '0;
                     done_q <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Every output below depends only on registered state.
   assign sel_acc     = $signed(snap[idx]);
   assign busy_o      = (state == STREAM);
   assign out_valid_o = (state == STREAM);
   assign done_o      = done_q;
   assign out_last_o  = (state == STREAM) && is_last;
   assign out_row_o   = RC_W'(32'(idx) / N);
   assign out_col_o   = RC_W'(32'(idx) % N);

   acc_requant #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_W    (SHIFT_W)
   ) u_requant (
      .acc   (sel_acc),
      .shift (shift_q),
      .data  (out_data_o)
   );

endmodule

// File: tb/tb_acc_drain.sv
// Randomized bench for acc_drain against a floor-division requantization model.
module tb_acc_drain;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int AW  = 64;
   localparam int SW  = 6;
   localparam int NPE = N * N;
   localparam int RW  = $clog2(N);
   localparam int EW  = 2 * RW + 1 + DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic [NPE*AW-1:0] acc_i = '0;
   logic [SW-1:0]     shift_i = '0;
   logic              out_ready_i = 1'b0;
   logic              busy_o, done_o, out_valid_o, out_last_o;
   logic [DW-1:0]     out_data_o;
   logic [RW-1:0]     out_row_o, out_col_o;

   logic signed [AW-1:0] acc_m [NPE];
   logic [EW-1:0]        exp_q [$];
   int                   err_cnt = 0;
   int                   chk_cnt = 0;
   int                   beats, cycles;

   logic signed [AW-1:0] rq_acc [9] = '{64'sd70000, -64'sd70000, 64'sd3, -64'sd3, -64'sd4,
                                        64'sd384, -64'sd1, 64'sh4000_0000_0000_0000,
                                        64'sh8000_0000_0000_0000};
   int                   rq_sh  [9] = '{0, 0, 1, 1, 1, 8, 63, 63, 63};
   logic [DW-1:0]        rq_exp [9] = '{16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF, 16'hFFFE,
                                        16'h0002, 16'h0000, 16'h0001, 16'hFFFF};

   acc_drain #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT_W(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .acc_i       (acc_i),
      .shift_i     (shift_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_row_o   (out_row_o),
      .out_col_o   (out_col_o),
      .out_last_o  (out_last_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: floor((acc + 2^(s-1)) / 2^s), then clamp to the signed output range.
   function automatic logic [DW-1:0] model_rq(input logic signed [AW-1:0] acc, input int sh);
      logic signed [127:0] num, d, q, hi, lo;
      int s;
      s = (sh > AW - 1) ? AW - 1 : sh;
      num = acc;
      if (s == 0) begin
         q = num;
      end else begin
         d = 128'sd1 <<< s;
         num = num + d / 128'sd2;
         q = num / d;
         if (num < 0 && (num % d) != 0) q = q - 128'sd1;
      end
      hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (DW - 1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q[DW-1:0];
   endfunction

   task automatic drive_acc();
      for (int k = 0; k < NPE; k++) acc_i[k*AW +: AW] = acc_m[k];
   endtask

   task automatic fill_idx();
      for (int k = 0; k < NPE; k++) acc_m[k] = AW'(k);
   endtask

   task automatic fill_rand();
      int unsigned r;
      for (int k = 0; k < NPE; k++) begin
         r = $urandom;
         case ($urandom_range(0, 2))
            0:       acc_m[k] = $signed(AW'($urandom_range(0, 2000))) - 64'sd1000;
            1:       acc_m[k] = {$urandom, $urandom};
            default: acc_m[k] = {{32{r[31]}}, r};
         endcase
      end
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_valid"}, out_valid_o, 0);
      chk({tag, "_data"}, out_data_o, 0);
      chk({tag, "_row"}, out_row_o, 0);
      chk({tag, "_col"}, out_col_o, 0);
      chk({tag, "_last"}, out_last_o, 0);
   endtask

   // Start a capture from IDLE; the scoreboard is loaded from the bench's own copy.
   task automatic do_start(input int sh);
      shift_i = SW'(sh);
      drive_acc();
      start_i = 1'b1;
      for (int k = 0; k < NPE; k++)
         exp_q.push_back({RW'(k / N), RW'(k % N), 1'(k == NPE - 1), model_rq(acc_m[k], sh)});
      step();
      start_i = 1'b0;
      chk("start_valid", out_valid_o, 1);
      chk("start_busy", busy_o, 1);
   endtask

   // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random.
   task automatic stream(input int mode, input bit scramble, input int st_a, input int st_b,
                         input int abort_at, output int n_beats, output int n_cyc);
      logic [EW-1:0] prev, cur, e;
      bit prev_stall, fire;
      n_beats = 0;
      n_cyc = 0;
      prev_stall = 0;
      prev = '0;
      while (n_cyc < 200) begin
         cur = {out_row_o, out_col_o, out_last_o, out_data_o};
         if (prev_stall) chk("stall_hold", cur, prev);
         chk("busy_eq_valid", busy_o, out_valid_o);
         case (mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = (n_cyc % 4 == 0) || (n_cyc % 4 == 3);
            default: out_ready_i = 1'($urandom_range(0, 1));
         endcase
         if (scramble) begin
            for (int k = 0; k < NPE; k++) acc_i[k*AW +: AW] = {$urandom, $urandom};
            shift_i = SW'($urandom);
         end
         fire = out_valid_o && out_ready_i;
         start_i = fire && ((n_beats + 1 == st_a) || (n_beats + 1 == st_b));
         if (fire) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat", cur, e);
            end
            n_beats++;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev = cur;
         step();
         n_cyc++;
         start_i = 1'b0;
         if (fire && (n_beats == NPE || n_beats == abort_at)) break;
      end
      chk("stream_in_time", n_cyc < 200, 1);
   endtask

   task automatic end_check();
      chk("beats", beats, NPE);
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 0);
      chk("done_valid", out_valid_o, 0);
      chk("q_empty", exp_q.size(), 0);
   endtask

   task automatic idle_check();
      step();
      chk("done_once", done_o, 0);
      chk("idle_valid", out_valid_o, 0);
   endtask

   initial begin
      // Reset with random inputs and a start request that must be ignored.
      fill_rand();
      drive_acc();
      shift_i = SW'($urandom);
      start_i = 1'b1;
      rst = 1'b1;
      repeat (3) begin
         step();
         zero_check("rst");
      end
      rst = 1'b0;
      start_i = 1'b0;
      step();
      zero_check("post_rst");

      // Basic stream: identity data, shift 0, ready always high.
      fill_idx();
      do_start(0);
      stream(0, 0, 0, 0, 0, beats, cycles);
      chk("basic_cycles", cycles, NPE);
      end_check();
      idle_check();

      // Backpressure while inputs change after the snapshot.
      fill_idx();
      do_start(0);
      stream(1, 1, 0, 0, 0, beats, cycles);
      end_check();
      idle_check();

      // Requantization corner cases on element 0.
      for (int i = 0; i < 9; i++) begin
         fill_rand();
         acc_m[0] = rq_acc[i];
         do_start(rq_sh[i]);
         chk("rq_literal", out_data_o, rq_exp[i]);
         chk("rq_model", model_rq(rq_acc[i], rq_sh[i]), rq_exp[i]);
         stream(0, 0, 0, 0, 0, beats, cycles);
         end_check();
         idle_check();
      end

      // Starts during the stream, including the final handshake, are ignored.
      fill_rand();
      do_start($urandom_range(0, 63));
      stream(0, 0, 3, NPE, 0, beats, cycles);
      end_check();
      idle_check();

      // A start in the done cycle is accepted.
      fill_rand();
      do_start($urandom_range(0, 63));
      stream(0, 0, 0, 0, 0, beats, cycles);
      end_check();
      fill_rand();
      do_start($urandom_range(0, 63));
      stream(2, 0, 0, 0, 0, beats, cycles);
      end_check();
      idle_check();

      // Reset after five beats discards the stream.
      fill_idx();
      do_start(0);
      stream(0, 0, 0, 0, 5, beats, cycles);
      chk("abort_beats", beats, 5);
      rst = 1'b1;
      step();
      zero_check("midrst");
      rst = 1'b0;
      exp_q.delete();
      step();
      zero_check("midrst_after");
      fill_rand();
      do_start($urandom_range(0, 63));
      stream(0, 0, 0, 0, 0, beats, cycles);
      end_check();
      idle_check();

      // Random traffic.
      repeat (6) begin
         fill_rand();
         do_start($urandom_range(0, 63));
         stream(2, 1, 0, 0, 0, beats, cycles);
         end_check();
         idle_check();
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
